dm_stall: RTL and testbench



---
 rtl/dm_stall.sv | 163 ++++++++++++++++
 tb/tb_dm_stall.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dm_stall.sv
// Multi-cycle byte/half/word data memory with configurable wait states and a valid/ready request/response handshake.
// Optional feature macro: DM_ERR_CHECK_EN (misalignment, invalid size and out-of-range faults).
module dm_stall #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic             a_we, a_uns, do_access, err, mem_we;
    logic [1:0]       a_size, eff_size, lane;
    logic [31:0]      a_addr, a_wdata, wd, word, rd;
    logic [3:0]       be;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sel_b;
    logic [15:0]      sel_h;
    logic             unused_addr_bits;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // With zero wait states the access happens at acceptance, so take the live request fields.
    assign a_we    = (state == IDLE) ? req_we       : we_q;
    assign a_uns   = (state == IDLE) ? req_unsigned : uns_q;
    assign a_size  = (state == IDLE) ? req_size     : size_q;
    assign a_addr  = (state == IDLE) ? req_addr     : addr_q;
    assign a_wdata = (state == IDLE) ? req_wdata    : wdata_q;

    assign do_access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 4'd0));
    assign idx       = a_addr[IDX_W+1:2];
    assign word      = mem[idx];
    assign mem_we    = do_access && a_we && !err;
    assign unused_addr_bits = ^a_addr;

    always_comb begin
        eff_size = a_size;
        lane     = a_addr[1:0];
        err      = 1'b0;
`ifdef DM_ERR_CHECK_EN
        if (a_size == 2'b11) err = 1'b1;
        if ((a_size == 2'b01) && a_addr[0]) err = 1'b1;
        if ((a_size == 2'b10) && (a_addr[1:0] != 2'b00)) err = 1'b1;
        if (a_addr[31:2] >= 30'(DEPTH)) err = 1'b1;
`else
        if (a_size == 2'b11) eff_size = 2'b10;
        if (eff_size == 2'b01) lane[0] = 1'b0;
        if (eff_size == 2'b10) lane = 2'b00;
`endif
    end

    always_comb begin
        be = 4'b0000;
        wd = a_wdata;
        case (eff_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        sel_h = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'b00:   sel_b = word[7:0];
            2'b01:   sel_b = word[15:8];
            2'b10:   sel_b = word[23:16];
            default: sel_b = word[31:24];
        endcase
        case (eff_size)
            2'b00:   rd = a_uns ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
            2'b01:   rd = a_uns ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
            default: rd = word;
        endcase
        if (a_we || err) rd = 32'd0;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(WAIT_CYCLES - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (do_access) begin
                rsp_rdata <= rd;
                rsp_err   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Memory contents survive rst_n; a store is committed only when its access actually happens.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dm_stall.sv
// Directed bench for dm_stall: scoreboard queue of expected {err, rdata}, latency and stall checks, reset mid-store.
module tb_dm_stall;
    localparam int DEPTH = 64;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    dm_stall #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        exp_q.push_back({err, rdata});
    endtask

    task automatic send_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic get_rsp(input string tag);
        int n;
        logic [32:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check({tag, "_latency"}, 64'(n), 64'(WAIT_CYCLES + 1));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, e[31:0]});
            check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, e[32]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        expect_rsp(exp_rdata, exp_err);
        send_req(we, size, uns, addr, wdata);
        get_rsp(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rsp_rdata"}, {32'd0, rsp_rdata}, 64'd0);
        check({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        access("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        access("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        access("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0);
        access("ld_w20", 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        access("ld_bs21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
        access("ld_bu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0);

        access("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE1234, 32'h0, 1'b0);
        access("st_h32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h00008001, 32'h0, 1'b0);
        access("ld_hs32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF8001, 1'b0);
        access("ld_hu30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h00001234, 1'b0);
        access("ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h80011234, 1'b0);

        access("st_w00", 1'b1, 2'b10, 1'b0, 32'h00, 32'h01020304, 32'h0, 1'b0);
        access("st_w04", 1'b1, 2'b10, 1'b0, 32'h04, 32'h55667788, 32'h0, 1'b0);
`ifdef DM_ERR_CHECK_EN
        access("err_ld_w02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
        access("err_st_h05", 1'b1, 2'b01, 1'b0, 32'h05, 32'h0000BEEF, 32'h0, 1'b1);
        access("err_ld_w04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h55667788, 1'b0);
        access("err_st_oob", 1'b1, 2'b10, 1'b0, DEPTH * 4, 32'h99999999, 32'h0, 1'b1);
        access("err_ld_oob", 1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0, 32'h0, 1'b1);
        access("err_ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h01020304, 1'b0);
        access("err_size3", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1);
`else
        access("al_ld_w02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h01020304, 1'b0);
        access("al_st_h05", 1'b1, 2'b01, 1'b0, 32'h05, 32'h0000BEEF, 32'h0, 1'b0);
        access("al_ld_w04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h5566BEEF, 1'b0);
        access("wr_st_oob", 1'b1, 2'b10, 1'b0, DEPTH * 4, 32'h99999999, 32'h0, 1'b0);
        access("wr_ld_oob", 1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0, 32'h99999999, 1'b0);
        access("wr_ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h99999999, 1'b0);
        access("sz3_as_word", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h5566BEEF, 1'b0);
`endif

        // Response back-pressure: a pending request must not be taken while RESP is held.
        access("st_w50", 1'b1, 2'b10, 1'b0, 32'h50, 32'h13579BDF, 32'h0, 1'b0);
        rsp_ready = 1'b0;
        expect_rsp(32'h13579BDF, 1'b0);
        send_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        get_rsp("stall_ld");
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h50;
        req_wdata = $urandom_range(1, 1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_rsp_rdata", {32'd0, rsp_rdata}, 64'h13579BDF);
            check("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_stall_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("post_stall_req_ready", {63'd0, req_ready}, 64'd1);
        access("ld_w50_after", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h13579BDF, 1'b0);

        // Reset while a store sits in WAIT: the store must be dropped.
        send_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h5A5A5A5A);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        access("ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h00000000, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
